// File: rtl/pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Hazard/flush sequencer for the 5-stage pipeline front end. Resolves
//   load-use, mult/div-busy and branch-mispredict hazards, tracks the
//   multi-cycle mult/div unit and keeps saturating performance counters.
//
// Ports
//   CLK            rising-edge clock
//   CLR_N          asynchronous active-low reset
//   ID_Rs, ID_Rt   source registers of the instruction in ID
//   ID_UseRs/Rt    ID instruction actually reads Rs / Rt
//   ID_IsMD        ID instruction is a mult/div
//   ID_ReadsHILO   ID instruction is mfhi/mflo
//   EX_MemRead     EX instruction is a load
//   EX_Rd          EX destination register
//   EX_Mispredict  EX branch resolved against the prediction
//   MD_Start       EX launches a mult/div this cycle
//   PC_En          PC write enable
//   IF_ID_En       IF/ID clock enable
//   IF_ID_Clr      IF/ID zero-load (effective only with IF_ID_En=1)
//   ID_EX_Clr      bubble insert into ID/EX
//   MD_Busy        mult/div result pending
//   StallCount     cycles with PC_En=0 (saturating)
//   FlushCount     mispredicts seen (saturating)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MD_LAT    = 32,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_IsMD,
  input  logic             ID_ReadsHILO,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             EX_Mispredict,
  input  logic             MD_Start,
  output logic             PC_En,
  output logic             IF_ID_En,
  output logic             IF_ID_Clr,
  output logic             ID_EX_Clr,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int MD_W = $clog2(MD_LAT + 1);
  localparam int FL_W = $clog2(FLUSH_CYC + 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [FL_W-1:0]  fl_cnt_q, fl_cnt_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu, mdh, fl;

  // Hazard detection and output priority: flush > stall > run.
  always_comb begin
    lu = EX_MemRead && (EX_Rd != 5'd0) &&
         ((ID_UseRs && (ID_Rs == EX_Rd)) || (ID_UseRt && (ID_Rt == EX_Rd)));
    MD_Busy = (md_cnt_q != '0);
    mdh     = MD_Busy && (ID_IsMD || ID_ReadsHILO);
    fl      = EX_Mispredict || (state_q == FLUSH);

    PC_En     = 1'b1;
    IF_ID_En  = 1'b1;
    IF_ID_Clr = 1'b0;
    ID_EX_Clr = 1'b0;
    if (fl) begin
      // Wrong-path instruction in ID is squashed; EX slot is only squashed
      // in the cycle the mispredict itself is resolved.
      IF_ID_Clr = 1'b1;
      ID_EX_Clr = EX_Mispredict;
    end else if (lu || mdh) begin
      PC_En     = 1'b0;
      IF_ID_En  = 1'b0;
      ID_EX_Clr = 1'b1;
    end
  end

  // Flush sequencer: extends IF_ID_Clr to FLUSH_CYC cycles per mispredict.
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    if (EX_Mispredict && (FLUSH_CYC > 1)) begin
      // A new mispredict (from RUN or FLUSH) restarts the full window.
      state_d  = FLUSH;
      fl_cnt_d = FL_W'(FLUSH_CYC - 1);
    end else if (state_q == FLUSH) begin
      fl_cnt_d = fl_cnt_q - FL_W'(1);
      if (fl_cnt_d == '0) begin
        state_d = RUN;
      end
    end
  end

  // Mult/div occupancy and perf counters.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (MD_Start && (md_cnt_q == '0)) begin
      md_cnt_d = MD_W'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end

    stall_cnt_d = stall_cnt_q;
    if (!PC_En && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    flush_cnt_d = flush_cnt_q;
    if (EX_Mispredict && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= RUN;
      fl_cnt_q    <= '0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fl_cnt_q    <= fl_cnt_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule
